// File: rtl/flash_xip_arbiter.sv
// flash_xip_arbiter: two-port round-robin SPI master for 03h single-word reads
// from the NOR flash on chip-select 0. Port 0 carries instruction fetches and
// port 1 carries data loads. Each accepted request returns one little-endian
// word.
// Optional feature: define FLASH_XIP_LASTWORD_EN to add a one-entry last-word
// buffer. A request that hits the buffer bypasses the SPI transaction.
module flash_xip_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  input  logic [23:0] req_addr_0,
  input  logic [23:0] req_addr_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  output logic        resp_valid_0,
  output logic        resp_valid_1,
  output logic [31:0] resp_data,
  output logic        sck,
  output logic [1:0]  ss,
  output logic        mosi,
  input  logic        miso
);

  localparam int              GW        = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [7:0]      HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic          ptr;
  logic          owner;
  logic          hit_q;
  logic [23:0]   addr_q;
  logic [31:0]   sh;
  logic [7:0]    hcnt;
  logic [5:0]    bitcnt;
  logic [GW-1:0] gcnt;
  logic          in_idle, grant_0, grant_1, accept;
  logic [23:0]   sel_addr;
  logic          half_end, shift_end;
  logic          hit;
  logic [31:0]   hit_data;

  // Outgoing bit n of the 64-bit frame: command, word-aligned address, then zeros.
  function automatic logic tx_bit(input logic [23:0] a, input logic [5:0] n);
    logic [31:0] w;
    w = {8'h03, a[23:2], 2'b00};
    return (n < 6'd32) ? w[5'd31 - n[4:0]] : 1'b0;
  endfunction

  // The flash streams the lowest address first, so that byte belongs in [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // The pointer port wins a tie. A lone requester always wins.
  assign in_idle   = (state == IDLE) && reset;
  assign grant_0   = in_idle && req_valid_0 && (!ptr || !req_valid_1);
  assign grant_1   = in_idle && req_valid_1 && ( ptr || !req_valid_0);
  assign accept    = grant_0 || grant_1;
  assign sel_addr  = grant_1 ? req_addr_1 : req_addr_0;
  assign half_end  = (hcnt == HALF_LAST);
  assign shift_end = half_end && sck && (bitcnt == 6'd63);

  assign req_ready_0  = grant_0;
  assign req_ready_1  = grant_1;
  assign resp_valid_0 = reset && (state == DONE) && !owner;
  assign resp_valid_1 = reset && (state == DONE) &&  owner;
  assign resp_data    = (reset && state == DONE) ? byte_swap(sh) : 32'h0;

`ifdef FLASH_XIP_LASTWORD_EN
  logic        lw_valid;
  logic [21:0] lw_tag;
  logic [31:0] lw_data;

  assign hit      = lw_valid && (lw_tag == sel_addr[23:2]);
  assign hit_data = lw_data;

  // Flash is read-only, so only reset can invalidate the buffered word.
  always_ff @(posedge clock) begin
    if (!reset)              lw_valid <= 1'b0;
    else if (state == DONE)  lw_valid <= 1'b1;
  end

  // Capture the word returned by every response, whether it came from SPI or from a hit.
  always_ff @(posedge clock) begin
    if (state == DONE) begin
      lw_tag  <= addr_q[23:2];
      lw_data <= sh;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A buffer hit returns to IDLE without a chip-select gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = hit ? DONE : SHIFT;
      SHIFT:   if (shift_end) state_nxt = DONE;
      DONE:    state_nxt = hit_q ? IDLE : GAP;
      GAP:     if (gcnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPI pins, sck divider, bit and gap counters, and the round-robin pointer.
  // mosi is updated on the same edge that drives sck low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr    <= 1'b0;
      sck    <= 1'b0;
      ss     <= 2'b11;
      mosi   <= 1'b0;
      hcnt   <= 8'd0;
      bitcnt <= 6'd0;
      gcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr    <= grant_0;
            hcnt   <= 8'd0;
            bitcnt <= 6'd0;
            sck    <= 1'b0;
            if (!hit) begin
              ss   <= 2'b10;
              mosi <= tx_bit(sel_addr, 6'd0);
            end
          end
        end
        SHIFT: begin
          if (half_end) begin
            hcnt <= 8'd0;
            sck  <= !sck;
            if (sck) begin
              if (bitcnt == 6'd63) begin
                ss   <= 2'b11;
                mosi <= 1'b0;
              end else begin
                bitcnt <= bitcnt + 6'd1;
                mosi   <= tx_bit(addr_q, bitcnt + 6'd1);
              end
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        DONE:    gcnt <= '0;
        GAP:     gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
  end

  // Request latch and receive shifter. miso is sampled on the edge that raises sck.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q <= sel_addr;
      owner  <= grant_1;
      hit_q  <= hit;
      if (hit) sh <= hit_data;
    end else if (state == SHIFT && half_end && !sck && bitcnt >= 6'd32) begin
      sh <= {sh[30:0], miso};
    end
  end

endmodule

// File: tb/tb_flash_xip_arbiter.sv
// Directed testbench for flash_xip_arbiter, with a behavioural SPI NOR slave.
// A second instance with CLK_DIV=1 and CS_GAP=1 is used for the back-to-back spacing check.
`timescale 1ns/1ps
module tb_flash_xip_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic [23:0] req_addr_0 = 24'h0, req_addr_1 = 24'h0;
  logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
  logic [31:0] resp_data;
  logic        sck, mosi;
  logic [1:0]  ss;
  logic        miso = 1'b0;

  logic        b_valid_0 = 1'b0;
  logic        b_ready_0, b_ready_1, b_rv0, b_rv1, b_sck, b_mosi;
  logic [31:0] b_data;
  logic [1:0]  b_ss;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  flash_xip_arbiter #(.CLK_DIV(2), .CS_GAP(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_data(resp_data), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  flash_xip_arbiter #(.CLK_DIV(1), .CS_GAP(1)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid_0(b_valid_0), .req_valid_1(1'b0),
    .req_addr_0(24'h000020), .req_addr_1(24'h000000),
    .req_ready_0(b_ready_0), .req_ready_1(b_ready_1),
    .resp_valid_0(b_rv0), .resp_valid_1(b_rv1),
    .resp_data(b_data), .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .miso(1'b1)
  );

  // Flash contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h11;
      24'h000011: return 8'h22;
      24'h000012: return 8'h33;
      24'h000013: return 8'h44;
      24'h000014: return 8'h55;
      24'h000015: return 8'h66;
      24'h000016: return 8'h77;
      24'h000017: return 8'h88;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // SPI slave, mode 0
  logic        ss0;
  assign ss0 = ss[0];
  int          rcnt = 0;
  int          ss_falls = 0;
  logic [31:0] rx = 32'h0;
  logic [31:0] cap_cmd = 32'h0;
  int          mk;
  logic [7:0]  mb;
  int          ss1_err = 0;

  always @(negedge ss0 or posedge sck) begin
    if (!ss0 && !sck) begin
      rcnt = 0;
      rx   = 32'h0;
      ss_falls++;
    end else if (!ss0 && sck) begin
      rx = {rx[30:0], mosi};
      rcnt++;
      if (rcnt == 32) cap_cmd = rx;
    end
  end

  always @(negedge sck) begin
    if (!ss0 && rcnt >= 32 && rcnt < 64) begin
      mk   = rcnt - 32;
      mb   = flash_byte(cap_cmd[23:0] + 24'(mk / 8));
      miso = mb[3'(7 - (mk % 8))];
    end
  end

  always @(negedge clock) if (reset && ss[1] !== 1'b1) ss1_err++;

  task automatic apply_reset();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    b_valid_0   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic do_read(input int port, input logic [23:0] a,
                         output logic [31:0] d, output int lat);
    int n;
    @(negedge clock);
    if (port == 0) begin req_valid_0 = 1'b1; req_addr_0 = a; end
    else           begin req_valid_1 = 1'b1; req_addr_1 = a; end
    n = 0;
    #1;
    while (!((port == 0) ? req_ready_0 : req_ready_1) && n < 2000) begin
      @(negedge clock); #1; n++;
    end
    @(posedge clock); #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    d   = 32'h0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clock);
      if ((port == 0) ? resp_valid_0 : resp_valid_1) begin
        d   = resp_data;
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0; req_valid_0 = 1'b1; req_valid_1 = 1'b1; req_addr_0 = 24'h10;
    repeat (2) @(negedge clock);
    #1;
    tests++; if ({req_ready_0, req_ready_1} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", {req_ready_0, req_ready_1}); end
    tests++; if (ss !== 2'b11) begin fails++; $display("FAIL reset_ss: got %b expected 11", ss); end
    tests++; if ({sck, mosi} !== 2'b00) begin fails++; $display("FAIL reset_sck_mosi: got %b expected 00", {sck, mosi}); end
    tests++; if ({resp_valid_0, resp_valid_1} !== 2'b00 || resp_data !== 32'h0) begin fails++; $display("FAIL reset_resp: got %b/%h expected 00/00000000", {resp_valid_0, resp_valid_1}, resp_data); end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; reset = 1'b1;
    @(negedge clock); #1;
    tests++; if (ss !== 2'b11 || sck !== 1'b0) begin fails++; $display("FAIL idle_pins: got ss=%b sck=%b expected 11/0", ss, sck); end
  endtask

  task automatic test_read_port0();
    logic [31:0] d; int lat;
    apply_reset();
    do_read(0, 24'h000010, d, lat);
    tests++; if (lat !== 257) begin fails++; $display("FAIL p0_latency: got %0d expected 257", lat); end
    tests++; if (d !== 32'h44332211) begin fails++; $display("FAIL p0_data: got %h expected 44332211", d); end
    tests++; if (cap_cmd !== 32'h03000010) begin fails++; $display("FAIL p0_cmd: got %h expected 03000010", cap_cmd); end
    tests++; if (ss1_err !== 0) begin fails++; $display("FAIL ss1_high: got %0d bad cycles expected 0", ss1_err); end
    #1;
    tests++; if (ss !== 2'b11 || sck !== 1'b0) begin fails++; $display("FAIL done_pins: got ss=%b sck=%b expected 11/0", ss, sck); end
  endtask

  task automatic test_read_port1();
    logic [31:0] d; int lat;
    apply_reset();
    do_read(1, 24'h000013, d, lat);
    tests++; if (cap_cmd !== 32'h03000010) begin fails++; $display("FAIL p1_cmd_aligned: got %h expected 03000010", cap_cmd); end
    tests++; if (d !== 32'h44332211) begin fails++; $display("FAIL p1_data: got %h expected 44332211", d); end
    tests++; if (lat !== 257) begin fails++; $display("FAIL p1_latency: got %0d expected 257", lat); end
  endtask

  task automatic test_arbitration();
    int g[4];
    int ng, nr0, nr1;
    ng = 0; nr0 = 0; nr1 = 0;
    apply_reset();
    @(negedge clock);
    req_addr_0 = 24'h000010; req_addr_1 = 24'h000014;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    for (int k = 0; k < 2000 && (nr0 + nr1) < 4; k++) begin
      if (ng >= 4) begin req_valid_0 = 1'b0; req_valid_1 = 1'b0; end
      #1;
      if (req_ready_0 && req_ready_1) begin
        tests++; fails++; $display("FAIL arb_both_ready: got 11 expected one-hot");
      end
      if (ng < 4 && req_ready_0) begin g[ng] = 0; ng++; end
      if (ng < 4 && req_ready_1) begin g[ng] = 1; ng++; end
      if (resp_valid_0) begin
        nr0++;
        tests++; if (resp_data !== 32'h44332211) begin fails++; $display("FAIL arb_data0: got %h expected 44332211", resp_data); end
      end
      if (resp_valid_1) begin
        nr1++;
        tests++; if (resp_data !== 32'h88776655) begin fails++; $display("FAIL arb_data1: got %h expected 88776655", resp_data); end
      end
      @(negedge clock);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tests++; if (ng !== 4 || g[0] !== 0 || g[1] !== 1 || g[2] !== 0 || g[3] !== 1) begin
      fails++; $display("FAIL arb_order: got n=%0d %0d%0d%0d%0d expected 0101", ng, g[0], g[1], g[2], g[3]);
    end
    tests++; if (nr0 !== 2 || nr1 !== 2) begin fails++; $display("FAIL arb_resp_count: got %0d/%0d expected 2/2", nr0, nr1); end
  endtask

  task automatic test_abort();
    logic [31:0] d; int lat; int stray;
    apply_reset();
    @(negedge clock);
    req_valid_0 = 1'b1; req_addr_0 = 24'h000010;
    @(posedge clock); #1;
    req_valid_0 = 1'b0;
    repeat (40) @(negedge clock);
    reset = 1'b0;
    #1;
    tests++; if (resp_valid_0 !== 1'b0) begin fails++; $display("FAIL abort_resp_now: got %b expected 0", resp_valid_0); end
    @(negedge clock); #1;
    tests++; if (ss !== 2'b11 || sck !== 1'b0 || mosi !== 1'b0) begin fails++; $display("FAIL abort_pins: got ss=%b sck=%b mosi=%b expected 11/0/0", ss, sck, mosi); end
    reset = 1'b1;
    stray = 0;
    repeat (400) begin
      @(negedge clock);
      if (resp_valid_0 || resp_valid_1) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL abort_no_resp: got %0d pulses expected 0", stray); end
    do_read(0, 24'h000014, d, lat);
    tests++; if (d !== 32'h88776655 || lat !== 257) begin fails++; $display("FAIL abort_recover: got %h lat %0d expected 88776655 lat 257", d, lat); end
  endtask

`ifdef FLASH_XIP_LASTWORD_EN
  task automatic test_lastword();
    logic [31:0] d; int lat; int f;
    apply_reset();
    do_read(0, 24'h000010, d, lat);
    tests++; if (d !== 32'h44332211 || lat !== 257) begin fails++; $display("FAIL lw_first: got %h lat %0d expected 44332211 lat 257", d, lat); end
    f = ss_falls;
    do_read(0, 24'h000010, d, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL lw_hit_latency: got %0d expected 1", lat); end
    tests++; if (d !== 32'h44332211) begin fails++; $display("FAIL lw_hit_data: got %h expected 44332211", d); end
    tests++; if (ss_falls !== f) begin fails++; $display("FAIL lw_hit_ss: got %0d falls expected %0d", ss_falls, f); end
    do_read(1, 24'h000014, d, lat);
    tests++; if (d !== 32'h88776655 || lat !== 257 || ss_falls !== f + 1) begin
      fails++; $display("FAIL lw_miss: got %h lat %0d falls %0d expected 88776655 lat 257 falls %0d", d, lat, ss_falls, f + 1);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int acc[3];
    int na, rc;
    logic [31:0] rd;
    na = 0; rc = -1; rd = 32'h0;
    apply_reset();
    @(negedge clock);
    b_valid_0 = 1'b1;
    for (int k = 0; k < 1000 && na < 3; k++) begin
      #1;
      if (b_rv0 && rc < 0) begin rc = cyc; rd = b_data; end
      if (b_ready_0) begin acc[na] = cyc; na++; end
      if (na < 3) @(negedge clock);
    end
    @(posedge clock); #1;
    b_valid_0 = 1'b0;
    tests++; if (na !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", na); end
    else begin
      tests++; if (acc[1] - acc[0] !== 131) begin fails++; $display("FAIL b2b_spacing1: got %0d expected 131", acc[1] - acc[0]); end
      tests++; if (acc[2] - acc[1] !== 131) begin fails++; $display("FAIL b2b_spacing2: got %0d expected 131", acc[2] - acc[1]); end
      tests++; if (rc - acc[0] !== 129) begin fails++; $display("FAIL b2b_latency: got %0d expected 129", rc - acc[0]); end
    end
    tests++; if (rd !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_data: got %h expected ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_read_port0();
    test_read_port1();
    test_arbitration();
    test_abort();
`ifdef FLASH_XIP_LASTWORD_EN
    test_lastword();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_xip_arbiter.md
# flash_xip_arbiter

SPI master that sequences single-word `03h` reads from the SPI NOR flash on chip-select 0 and shares it between two requesters, an instruction-fetch port and a data-load port. It sits between the CPU-side fetch/load paths and the `flash` SPI slave. The block generates `sck` and `ss`, shifts out command and address, shifts in 32 data bits, and returns one little-endian word per accepted request.

## Interface
- `CLK_DIV`, 2: `sck` half-period in `clock` cycles; legal range 1..255.
- `CS_GAP`, 2: `ss` high cycles between transactions; minimum 1.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid_0`, `req_valid_1`  in  1  read request, port 0 (fetch) / port 1 (load).
- `req_addr_0`, `req_addr_1`  in  24  byte address in flash space.
- `req_ready_0`, `req_ready_1`  out  1  request accepted when valid && ready.
- `resp_valid_0`, `resp_valid_1`  out  1  one-cycle pulse, response data valid.
- `resp_data`  out  32  response word, shared by both ports, qualified by `resp_valid_*`.
- `sck`  out  1  SPI clock, mode 0, idles low.
- `ss`  out  2  chip selects, active-low; `ss[1]` tied high.
- `mosi`  out  1  master out.
- `miso`  in  1  master in.

## Operation
- FSM states: IDLE, SHIFT, DONE, GAP.
- IDLE: `ss=2'b11`, `sck=0`. Round-robin arbitration. Pointer starts at port 0. On simultaneous requests the pointer port wins. After any grant the pointer moves to the other port. Only the winning port sees `req_ready=1`, combinationally from valid, and only in IDLE. On acceptance, latch address and owner, then go to SHIFT.
- SHIFT: `ss[0]=0`. 64 `sck` periods, bit counter 0..63.
  - Bits 0..31 drive `mosi` MSB-first: `8'h03`, then `{addr[23:2],2'b00}`. Address bits [1:0] are always sent as zero.
  - `mosi` changes only while `sck` is low. The bit is valid from the start of the low phase.
  - During periods 32..63, `miso` is sampled in the `clock` cycle where `sck` goes 0→1, i.e. the value before the slave shifts. It is shifted MSB-first into a 32-bit register `sh`.
  - `mosi=0` during bits 32..63.
- DONE, 1 cycle: `ss=2'b11`. Pulse the owner's `resp_valid`. Drive `resp_data={sh[7:0],sh[15:8],sh[23:16],sh[31:24]}`, so the byte at the lowest address lands in [7:0].
- GAP: `ss` high for `CS_GAP` cycles, which resets the slave, then return to IDLE.
- No backpressure on responses. Requesters must accept `resp_valid`.
- Reset low in any state: IDLE next cycle, pointer=0. Outputs go to `ss=2'b11`, `sck=0`, `mosi=0`, `resp_valid_*=0`, `resp_data=0`, `req_ready_*=0` during reset. No response is issued for an aborted transaction.

## Timing
- Accept at cycle T. `ss[0]` falls at T+1. First `sck` rise at T+1+`CLK_DIV`.
- SHIFT lasts `128*CLK_DIV` cycles. `resp_valid` occurs at T+1+`128*CLK_DIV`.
- Next acceptance at the earliest at T+2+`128*CLK_DIV`+`CS_GAP`.
- `sck`, `ss`, `mosi` are all registered; there are no combinational paths from `miso`.

## Configuration
- `FLASH_XIP_LASTWORD_EN`: adds a one-entry last-word buffer of tag `addr[23:2]`, data, and valid bit.
  - Valid is cleared only by reset, because flash is read-only. The buffer is updated at every DONE.
  - In IDLE, an accepted request whose tag matches a valid entry skips SHIFT/GAP and goes straight to DONE. `resp_valid` then occurs at T+1 with the buffered data, and `ss` stays high.
  - Arbitration and pointer update are unchanged.
- Without the macro, every request performs a full SPI transaction.

## Test plan
- Flash bytes at 0x000010..13 = 11,22,33,44. Port 0 reads 0x000010 with `CLK_DIV=2` -> `resp_valid_0` at T+257 with `resp_data=0x44332211`. `mosi` captured on `sck` rises = 0x03 then 0x000010. `ss[1]` stays 1 throughout.
- Port 1 reads 0x000013 -> the SPI address is sent as 0x000010 and `resp_data=0x44332211`.
- Both ports request from reset -> port 0 is granted first, port 1 is granted second. With both held valid, grants alternate 0,1,0,1.
- Reset deasserted for 40 cycles of a transaction, then reasserted -> no `resp_valid`. Next cycle `ss=2'b11` and `sck=0`. A subsequent read returns correct data.
- With `FLASH_XIP_LASTWORD_EN`, reading 0x000010 twice -> the second response comes at T+1, `ss` never falls, and the data matches. A read of 0x000014 performs full SPI.
- With `CLK_DIV=1` and `CS_GAP=1`, back-to-back reads from port 0 -> accept-to-accept spacing is 131 cycles.
